// File: rtl/sound_pkg.sv
// Shared constants, PCM type and DC-blocking helper for the I2S sound output.
package sound_pkg;

   localparam int unsigned PCM_OFFSET = 30720;
   localparam int unsigned PCM_SHIFT  = 7;
   localparam int unsigned MIX_W      = 9;
   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned HPF_ACC_W  = 24;

   typedef logic signed [15:0]          pcm_t;
   typedef logic signed [HPF_ACC_W-1:0] hpf_acc_t;

   function automatic pcm_t sat16(input logic signed [16:0] v);
      if (v > 17'sd32767)
         return 16'sh7FFF;
      else if (v < -17'sd32768)
         return 16'sh8000;
      else
         return $signed(v[15:0]);
   endfunction

   // y = x - (avg >>> 8); avg[23:8] is the arithmetic shift already truncated to 16 bits
   function automatic pcm_t hpf_y(input pcm_t x, input hpf_acc_t avg);
      logic signed [16:0] d;
      d = {x[15], x} - {avg[HPF_ACC_W-1], avg[HPF_ACC_W-1:8]};
      return sat16(d);
   endfunction

endpackage

// File: rtl/sound_side_mixer.sv
// One stereo side: sums enabled 4-bit channels, scales by volume, re-centres to signed PCM.
module sound_side_mixer
   import sound_pkg::*;
(
   input  logic       I_CLK_33MHZ,
   input  logic       I_RESET,
   input  logic [3:0] ch1_sample,
   input  logic [3:0] ch2_sample,
   input  logic [3:0] ch3_sample,
   input  logic [3:0] ch4_sample,
   input  logic [3:0] ch_en,
   input  logic [2:0] vol,
   input  logic       master_en,
   output pcm_t       pcm
);

   logic [5:0]       sum;
   logic [3:0]       vol_p1;
   logic [MIX_W-1:0] mix;
   logic [15:0]      scaled;
   logic [15:0]      pcm_next;

   // ch_en[0] selects channel 1 ... ch_en[3] selects channel 4
   always_comb begin
      sum = '0;
      if (ch_en[0]) sum = sum + {2'b00, ch1_sample};
      if (ch_en[1]) sum = sum + {2'b00, ch2_sample};
      if (ch_en[2]) sum = sum + {2'b00, ch3_sample};
      if (ch_en[3]) sum = sum + {2'b00, ch4_sample};
      vol_p1   = {1'b0, vol} + 4'd1;
      mix      = MIX_W'(sum) * MIX_W'(vol_p1);
      scaled   = 16'(mix) << PCM_SHIFT;
      pcm_next = master_en ? (scaled - 16'(PCM_OFFSET)) : '0;
   end

   always_ff @(posedge I_CLK_33MHZ) begin
      if (I_RESET)
         pcm <= '0;
      else
         pcm <= $signed(pcm_next);
   end

endmodule

// File: rtl/sound_output_i2s_tx.sv
// APU stereo mixer and I2S transmitter. Optional DC-blocking filter: define SOUND_OUT_HPF_EN.
module sound_output_i2s_tx
   import sound_pkg::*;
#(
   parameter int unsigned BCLK_DIV = 8,
   parameter int unsigned SAMPLE_W = 16
)(
   input  logic       I_CLK_33MHZ,
   input  logic       I_RESET,
   input  logic [3:0] I_CH1_SAMPLE,
   input  logic [3:0] I_CH2_SAMPLE,
   input  logic [3:0] I_CH3_SAMPLE,
   input  logic [3:0] I_CH4_SAMPLE,
   input  logic [7:0] I_NR50,
   input  logic [7:0] I_NR51,
   input  logic       I_NR52_MASTER_EN,
   output logic       O_I2S_BCLK,
   output logic       O_I2S_LRCK,
   output logic       O_I2S_SDATA,
   output logic       O_SAMPLE_STROBE
);

   localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [DIV_W-1:0]    div_cnt;
   logic                bclk;
   logic                bclk_fall;
   logic                frame_wrap;
   logic [5:0]          bit_cnt;
   logic [5:0]          bit_cnt_nxt;
   logic [SAMPLE_W-1:0] sr_l;
   logic [SAMPLE_W-1:0] sr_r;
   logic                sdata;
   logic                strobe;
   logic                in_data;
   pcm_t                mix_l;
   pcm_t                mix_r;
   pcm_t                tx_l;
   pcm_t                tx_r;
   logic                unused_vin;

   assign unused_vin = I_NR50[7] ^ I_NR50[3];

   sound_side_mixer u_mix_l (
      .I_CLK_33MHZ (I_CLK_33MHZ),
      .I_RESET     (I_RESET),
      .ch1_sample  (I_CH1_SAMPLE),
      .ch2_sample  (I_CH2_SAMPLE),
      .ch3_sample  (I_CH3_SAMPLE),
      .ch4_sample  (I_CH4_SAMPLE),
      .ch_en       (I_NR51[7:4]),
      .vol         (I_NR50[6:4]),
      .master_en   (I_NR52_MASTER_EN),
      .pcm         (mix_l)
   );

   sound_side_mixer u_mix_r (
      .I_CLK_33MHZ (I_CLK_33MHZ),
      .I_RESET     (I_RESET),
      .ch1_sample  (I_CH1_SAMPLE),
      .ch2_sample  (I_CH2_SAMPLE),
      .ch3_sample  (I_CH3_SAMPLE),
      .ch4_sample  (I_CH4_SAMPLE),
      .ch_en       (I_NR51[3:0]),
      .vol         (I_NR50[2:0]),
      .master_en   (I_NR52_MASTER_EN),
      .pcm         (mix_r)
   );

   always_ff @(posedge I_CLK_33MHZ) begin
      if (I_RESET) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign bclk_fall   = (div_cnt == DIV_W'(BCLK_DIV - 1)) && bclk;
   assign bit_cnt_nxt = bit_cnt + 6'd1;
   assign frame_wrap  = bclk_fall && (bit_cnt == 6'(FRAME_BITS - 1));

`ifdef SOUND_OUT_HPF_EN
   hpf_acc_t avg_l;
   hpf_acc_t avg_r;

   always_comb begin
      tx_l = hpf_y(mix_l, avg_l);
      tx_r = hpf_y(mix_r, avg_r);
   end

   always_ff @(posedge I_CLK_33MHZ) begin
      if (I_RESET) begin
         avg_l <= '0;
         avg_r <= '0;
      end else if (frame_wrap) begin
         avg_l <= avg_l + {{(HPF_ACC_W-16){tx_l[15]}}, tx_l};
         avg_r <= avg_r + {{(HPF_ACC_W-16){tx_r[15]}}, tx_r};
      end
   end
`else
   always_comb begin
      tx_l = mix_l;
      tx_r = mix_r;
   end
`endif

   // Slot bit k = 1..SAMPLE_W carries data; k = 0 is the one-BCLK I2S delay bit
   assign in_data = (bit_cnt_nxt[4:0] != 5'd0) && (bit_cnt_nxt[4:0] <= 5'(SAMPLE_W));

   always_ff @(posedge I_CLK_33MHZ) begin
      if (I_RESET) begin
         bit_cnt <= '0;
         sr_l    <= '0;
         sr_r    <= '0;
         sdata   <= 1'b0;
         strobe  <= 1'b0;
      end else begin
         strobe <= frame_wrap;
         if (bclk_fall) begin
            bit_cnt <= bit_cnt_nxt;
            if (frame_wrap) begin
               sr_l  <= SAMPLE_W'({16'b0, tx_l});
               sr_r  <= SAMPLE_W'({16'b0, tx_r});
               sdata <= 1'b0;
            end else if (in_data) begin
               if (bit_cnt_nxt[5]) begin
                  sdata <= sr_r[SAMPLE_W-1];
                  sr_r  <= sr_r << 1;
               end else begin
                  sdata <= sr_l[SAMPLE_W-1];
                  sr_l  <= sr_l << 1;
               end
            end else begin
               sdata <= 1'b0;
            end
         end
      end
   end

   assign O_I2S_BCLK      = bclk;
   assign O_I2S_LRCK      = bit_cnt[5];
   assign O_I2S_SDATA     = sdata;
   assign O_SAMPLE_STROBE = strobe;

endmodule

// File: tb/tb_sound_output_i2s_tx.sv
// Directed bench for sound_output_i2s_tx: decodes I2S frames and compares against hand values.
module tb_sound_output_i2s_tx;

   logic       clk;
   logic       rst;
   logic [3:0] ch1, ch2, ch3, ch4;
   logic [7:0] nr50, nr51;
   logic       master;
   logic       bclk, lrck, sdata, strobe;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0]  nr50;
      logic [7:0]  nr51;
      logic [3:0]  c1, c2, c3, c4;
      logic        master;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   vec_t vecs[7];

   sound_output_i2s_tx #(.BCLK_DIV(8), .SAMPLE_W(16)) dut (
      .I_CLK_33MHZ      (clk),
      .I_RESET          (rst),
      .I_CH1_SAMPLE     (ch1),
      .I_CH2_SAMPLE     (ch2),
      .I_CH3_SAMPLE     (ch3),
      .I_CH4_SAMPLE     (ch4),
      .I_NR50           (nr50),
      .I_NR51           (nr51),
      .I_NR52_MASTER_EN (master),
      .O_I2S_BCLK       (bclk),
      .O_I2S_LRCK       (lrck),
      .O_I2S_SDATA      (sdata),
      .O_SAMPLE_STROBE  (strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_total++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   function automatic logic [15:0] slot_word(input logic [63:0] b, input int base);
      logic [15:0] w;
      for (int j = 0; j < 16; j++) w[15-j] = b[base+1+j];
      return w;
   endfunction

   function automatic logic [63:0] pad_mask();
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++)
         if ((i % 32) == 0 || (i % 32) > 16) m[i] = 1'b1;
      return m;
   endfunction

   // Waits for the next strobe, then records SDATA/LRCK at each of the 64 BCLK rising edges.
   task automatic capture_frame(input int drop_at, output logic [63:0] bits, output logic [63:0] lr);
      int   cyc;
      int   idx;
      logic prev;
      bits = '0;
      lr   = '0;
      cyc  = 0;
      while (strobe !== 1'b1 && cyc < 2100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 2100) note_fail("strobe_wait");
      prev = bclk;
      idx  = 0;
      cyc  = 0;
      while (idx < 64 && cyc < 1100) begin
         @(negedge clk);
         cyc++;
         if (bclk === 1'b1 && prev === 1'b0) begin
            bits[idx] = sdata;
            lr[idx]   = lrck;
            if (idx == drop_at) master = 1'b0;
            idx++;
         end
         prev = bclk;
      end
      if (idx < 64) note_fail("bclk_wait");
   endtask

   task automatic measure_release();
      int n, t_lr, t_st, t_st2;
      n = 0; t_lr = -1; t_st = -1; t_st2 = -1;
      rst = 1'b0;
      while (n < 2200 && t_st2 < 0) begin
         @(negedge clk);
         n++;
         if (lrck === 1'b1 && t_lr < 0) t_lr = n;
         if (strobe === 1'b1) begin
            if (t_st < 0) t_st = n;
            else if (n > t_st + 1) t_st2 = n;
            else note_fail("strobe_width");
         end
      end
      check("lrck_rise", 64'(t_lr), 64'd512);
      check("strobe_first", 64'(t_st), 64'd1024);
      check("strobe_period", 64'(t_st2 - t_st), 64'd1024);
   endtask

   logic [63:0] bits, lr;
   logic [15:0] lw, rw;
   int          cyc;

   initial begin
      vecs[0] = '{8'h77, 8'h11, 4'd15, 4'd0,  4'd0,  4'd0,  1'b1, 16'hC400, 16'hC400};
      vecs[1] = '{8'h77, 8'hFF, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 16'h7800, 16'h7800};
      vecs[2] = '{8'h70, 8'hF0, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 16'h7800, 16'h8800};
      vecs[3] = '{8'h77, 8'hFF, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 16'h0000, 16'h0000};
      vecs[4] = '{8'h31, 8'h21, 4'd5,  4'd10, 4'd7,  4'd3,  1'b1, 16'h9C00, 16'h8D00};
      vecs[5] = '{8'h88, 8'h84, 4'd1,  4'd2,  4'd9,  4'd12, 1'b1, 16'h8E00, 16'h8C80};
      vecs[6] = '{8'h77, 8'hFF, 4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 16'h8800, 16'h8800};

      rst = 1'b1; master = 1'b1;
      nr50 = 8'h77; nr51 = 8'hFF;
      ch1 = 4'd15; ch2 = 4'd15; ch3 = 4'd15; ch4 = 4'd15;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({bclk, lrck, sdata, strobe}), 64'd0);
      measure_release();

      // Abort mid-frame while in the right slot with BCLK high
      cyc = 0;
      while (!(lrck === 1'b1 && bclk === 1'b1) && cyc < 1100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 1100) note_fail("midframe_wait");
      rst = 1'b1;
      @(negedge clk);
      check("midframe_reset_outputs", 64'({bclk, lrck, sdata, strobe}), 64'd0);
      repeat (2) @(negedge clk);
      measure_release();

      for (int v = 0; v < 7; v++) begin
         nr50 = vecs[v].nr50; nr51 = vecs[v].nr51; master = vecs[v].master;
         ch1 = vecs[v].c1; ch2 = vecs[v].c2; ch3 = vecs[v].c3; ch4 = vecs[v].c4;
         capture_frame(-1, bits, lr);
         capture_frame(-1, bits, lr);
         lw = slot_word(bits, 0);
         rw = slot_word(bits, 32);
         check($sformatf("vec%0d_left", v), 64'(lw), 64'(vecs[v].exp_l));
         check($sformatf("vec%0d_right", v), 64'(rw), 64'(vecs[v].exp_r));
         check($sformatf("vec%0d_pad", v), bits & pad_mask(), 64'd0);
         check($sformatf("vec%0d_lrck", v), lr, 64'hFFFFFFFF_00000000);
      end

      // NR52 drop at bit_cnt 20: current frame intact, next frame silent
      nr50 = 8'h77; nr51 = 8'hFF; master = 1'b1;
      ch1 = 4'd15; ch2 = 4'd15; ch3 = 4'd15; ch4 = 4'd15;
      capture_frame(-1, bits, lr);
      capture_frame(20, bits, lr);
      check("drop_cur_left", 64'(slot_word(bits, 0)), 64'h7800);
      check("drop_cur_right", 64'(slot_word(bits, 32)), 64'h7800);
      capture_frame(-1, bits, lr);
      check("drop_next_left", 64'(slot_word(bits, 0)), 64'h0000);
      check("drop_next_right", 64'(slot_word(bits, 32)), 64'h0000);

      // Constant full-scale input from a fresh reset
      master = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      capture_frame(-1, bits, lr);
      check("hold_first_left", 64'(slot_word(bits, 0)), 64'h7800);
      check("hold_first_right", 64'(slot_word(bits, 32)), 64'h7800);
`ifdef SOUND_OUT_HPF_EN
      begin
         int prev_mag, mag;
         lw = slot_word(bits, 0);
         prev_mag = (lw[15]) ? -int'($signed(lw)) : int'($signed(lw));
         for (int f = 0; f < 30; f++) begin
            capture_frame(-1, bits, lr);
            lw  = slot_word(bits, 0);
            mag = (lw[15]) ? -int'($signed(lw)) : int'($signed(lw));
            check($sformatf("hpf_decay%0d", f), 64'(mag < prev_mag), 64'd1);
            prev_mag = mag;
         end
      end
`else
      for (int f = 0; f < 3; f++) begin
         capture_frame(-1, bits, lr);
         check($sformatf("hold%0d_left", f), 64'(slot_word(bits, 0)), 64'h7800);
         check($sformatf("hold%0d_right", f), 64'(slot_word(bits, 32)), 64'h7800);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
